// File: rtl/tbl_packer.sv
// Flat packed lookup table write side: indexed writes, auto-increment bursts, clear sweep.
// Latency: accepted beat visible on ins one edge later; wr_ready is low while clearing or clr is asserted.
// Optional per-entry valid flags are enabled by defining TBL_PACK_VLD_EN.
module tbl_packer #(
    parameter int                 ENTRIES  = 32,
    parameter int                 IDX_W    = 5,
    parameter int                 DATA_W   = 20,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_burst,
    input  logic                      wr_last,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [ENTRIES*DATA_W-1:0] ins,
    output logic                      busy,
    output logic                      wr_err
`ifdef TBL_PACK_VLD_EN
    ,
    output logic [ENTRIES-1:0]        vld
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [IDX_W:0]   ENTRIES_C = ENTRIES[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

    logic [1:0]                          state_q, state_d;
    logic [IDX_W-1:0]                    ptr_q, ptr_d;
    logic                                err_q, err_d;
    logic [ENTRIES-1:0][DATA_W-1:0]      tbl_q;

    logic                                we;
    logic [IDX_W-1:0]                    waddr;
    logic [DATA_W-1:0]                   wdat;
    logic                                idx_oor;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    assign idx_oor  = ({1'b0, wr_idx} >= ENTRIES_C);
    assign wr_ready = (state_q != ST_CLEAR) && !clr;
    assign busy     = (state_q == ST_CLEAR);
    assign wr_err   = err_q;
    assign ins      = tbl_q;

    // clr has priority over a same-cycle beat; wr_ready already masks it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = ptr_q;
        wdat    = wr_data;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (wr_valid) begin
                    if (idx_oor) begin
                        err_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = wr_idx;
                        if (wr_burst) begin
                            ptr_d = idx_inc(wr_idx);
                            if (!wr_last) begin
                                state_d = ST_BURST;
                            end
                        end
                    end
                end
            end
            ST_BURST: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (wr_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    ptr_d = idx_inc(ptr_q);
                    if (wr_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = ptr_q;
                wdat  = INIT_VAL;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= INIT_VAL;
            end
        end else if (we) begin
            tbl_q[waddr] <= wdat;
        end
    end

`ifdef TBL_PACK_VLD_EN
    logic [ENTRIES-1:0] vld_q;

    // Beats set the flag, the sweep clears it; both go through the same write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (we) begin
            vld_q[waddr] <= (state_q != ST_CLEAR);
        end
    end

    assign vld = vld_q;
`endif

endmodule

// File: tb/tb_tbl_packer.sv
module tb_tbl_packer;
    localparam int NA = 32;
    localparam int NB = 20;
    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr, wr_valid, wr_burst, wr_last;
    logic [4:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic wr_ready, busy, wr_err;
    logic [NA*DW-1:0] ins;

    logic b_clr, b_wr_valid, b_wr_burst, b_wr_last;
    logic [4:0] b_wr_idx;
    logic [DW-1:0] b_wr_data;
    logic b_wr_ready, b_busy, b_wr_err;
    logic [NB*DW-1:0] b_ins;
`ifdef TBL_PACK_VLD_EN
    logic [NA-1:0] vld;
    logic [NB-1:0] b_vld;
`endif

    tbl_packer #(.ENTRIES(NA), .IDX_W(5), .DATA_W(DW), .INIT_VAL('0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_burst(wr_burst), .wr_last(wr_last), .wr_idx(wr_idx), .wr_data(wr_data),
        .ins(ins), .busy(busy), .wr_err(wr_err)
`ifdef TBL_PACK_VLD_EN
        , .vld(vld)
`endif
    );

    tbl_packer #(.ENTRIES(NB), .IDX_W(5), .DATA_W(DW), .INIT_VAL('0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_burst(b_wr_burst), .wr_last(b_wr_last), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
        .ins(b_ins), .busy(b_busy), .wr_err(b_wr_err)
`ifdef TBL_PACK_VLD_EN
        , .vld(b_vld)
`endif
    );

    // Reference model: entry arrays plus "burst open / next address / sweep cycles left".
    int m_ent[NA];
    bit m_vld[NA];
    bit m_burst;
    int m_ptr;
    int m_clr_left;
    bit m_err;
    int b_ent[NB];
    bit b_vm[NB];
    bit b_burst;
    int b_ptr;
    bit b_err;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [NA*DW-1:0] obs, input logic [NA*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NA*DW-1:0] pack_a();
        logic [NA*DW-1:0] r;
        for (int i = 0; i < NA; i++) r[i*DW +: DW] = DW'(m_ent[i]);
        return r;
    endfunction

    function automatic logic [NA*DW-1:0] pack_b();
        logic [NA*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[i*DW +: DW] = DW'(b_ent[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin m_ent[i] = 0; m_vld[i] = 0; end
        for (int i = 0; i < NB; i++) begin b_ent[i] = 0; b_vm[i] = 0; end
        m_burst = 0; m_ptr = 0; m_clr_left = 0; m_err = 0;
        b_burst = 0; b_ptr = 0; b_err = 0;
    endtask

    task automatic model_edge();
        int a;
        m_err = 0;
        if (m_clr_left > 0) begin
            m_ent[NA - m_clr_left] = 0;
            m_vld[NA - m_clr_left] = 0;
            m_clr_left--;
        end else if (clr) begin
            m_burst = 0;
            m_clr_left = NA;
        end else if (wr_valid) begin
            if (!m_burst) begin
                a = int'(wr_idx);
                if (a >= NA) m_err = 1;
                else begin
                    m_ent[a] = int'(wr_data); m_vld[a] = 1;
                    if (wr_burst && !wr_last) begin m_burst = 1; m_ptr = (a + 1) % NA; end
                end
            end else begin
                m_ent[m_ptr] = int'(wr_data); m_vld[m_ptr] = 1;
                m_ptr = (m_ptr + 1) % NA;
                if (wr_last) m_burst = 0;
            end
        end
        b_err = 0;
        if (b_wr_valid) begin
            if (!b_burst) begin
                a = int'(b_wr_idx);
                if (a >= NB) b_err = 1;
                else begin
                    b_ent[a] = int'(b_wr_data); b_vm[a] = 1;
                    if (b_wr_burst && !b_wr_last) begin b_burst = 1; b_ptr = (a + 1) % NB; end
                end
            end else begin
                b_ent[b_ptr] = int'(b_wr_data); b_vm[b_ptr] = 1;
                b_ptr = (b_ptr + 1) % NB;
                if (b_wr_last) b_burst = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ins", ins, pack_a());
        chk("busy", busy, (m_clr_left > 0));
        chk("wr_err", wr_err, m_err);
        chk("b_ins", b_ins, pack_b());
        chk("b_wr_err", b_wr_err, b_err);
        chk("b_busy", b_busy, 1'b0);
`ifdef TBL_PACK_VLD_EN
        begin
            logic [NA-1:0] va;
            logic [NB-1:0] vb;
            for (int i = 0; i < NA; i++) va[i] = m_vld[i];
            for (int i = 0; i < NB; i++) vb[i] = b_vm[i];
            chk("vld", vld, va);
            chk("b_vld", b_vld, vb);
        end
`endif
    endtask

    // Inputs are set just after an edge; ready is checked before the next edge, state after it.
    task automatic cyc();
        #1;
        chk("wr_ready", wr_ready, (m_clr_left == 0 && !clr));
        chk("b_wr_ready", b_wr_ready, !b_clr);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic beat(input int idx, input logic [DW-1:0] d, input bit bu, input bit la);
        clr = 0; wr_valid = 1; wr_idx = 5'(idx); wr_data = d; wr_burst = bu; wr_last = la;
        cyc();
    endtask

    task automatic idle(input int n);
        clr = 0; wr_valid = 0; b_wr_valid = 0;
        repeat (n) cyc();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ins"}, ins, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, wr_err, 1'b0);
        chk({tag, "_ready"}, wr_ready, 1'b1);
        chk({tag, "_b_ins"}, b_ins, '0);
`ifdef TBL_PACK_VLD_EN
        chk({tag, "_vld"}, vld, '0);
`endif
    endtask

    logic [DW-1:0] d[4];
    logic [NA*DW-1:0] snap;
    int bc;

    initial begin
        rst_n = 0;
        clr = 0; wr_valid = 0; wr_burst = 0; wr_last = 0; wr_idx = 0; wr_data = 0;
        b_clr = 0; b_wr_valid = 0; b_wr_burst = 0; b_wr_last = 0; b_wr_idx = 0; b_wr_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1;
        idle(1);
        reset_checks("post_reset");

        // Single indexed write
        beat(3, 20'hABCDE, 0, 0);
        wr_valid = 0;
        chk("t2_entry3", ins[79:60], 20'hABCDE);
        idle(1);

        // Burst wrapping 30,31,0,1
        for (int i = 0; i < 4; i++) d[i] = DW'($urandom_range(0, (1 << DW) - 1));
        beat(30, d[0], 1, 0);
        beat($urandom_range(0, 31), d[1], 1'($urandom_range(0, 1)), 0);
        beat($urandom_range(0, 31), d[2], 1'($urandom_range(0, 1)), 0);
        beat($urandom_range(0, 31), d[3], 1'($urandom_range(0, 1)), 1);
        idle(1);
        chk("t3_e30", ins[30*DW +: DW], d[0]);
        chk("t3_e31", ins[31*DW +: DW], d[1]);
        chk("t3_e0", ins[0 +: DW], d[2]);
        chk("t3_e1", ins[DW +: DW], d[3]);
        chk("t3_e2", ins[2*DW +: DW], 20'h0);
        beat(10, 20'h12345, 0, 0);
        idle(1);
        chk("t3_idle_after", ins[10*DW +: DW], 20'h12345);

        // Fill table then clear sweep; beats offered during the sweep must be refused
        for (int i = 0; i < NA; i++) beat(i, DW'($urandom_range(1, (1 << DW) - 1)), 0, 0);
        idle(1);
        clr = 1; wr_valid = 0;
        cyc();
        bc = busy ? 1 : 0;
        clr = 0;
        for (int k = 0; k < NA; k++) begin
            wr_valid = 1; wr_idx = 5'($urandom_range(0, 31)); wr_data = DW'($urandom);
            wr_burst = 0; wr_last = 0;
            cyc();
            if (busy) bc++;
        end
        wr_valid = 0;
        chk("t4_busy_cycles", 32'(bc), 32'd32);
        chk("t4_all_init", ins, '0);
        #1;
        chk("t4_ready_after", wr_ready, 1'b1);

        // 20-entry instance: out-of-range beat
        b_wr_valid = 1; b_wr_idx = 5; b_wr_data = 20'h5A5A5; b_wr_burst = 0; b_wr_last = 0;
        cyc();
        snap = {240'b0, b_ins};
        b_wr_idx = 25; b_wr_data = 20'hFFFFF; b_wr_burst = 1;
        cyc();
        chk("t5_err_pulse", b_wr_err, 1'b1);
        chk("t5_ins_same", b_ins, snap);
        b_wr_idx = 7; b_wr_data = 20'h00777; b_wr_burst = 0;
        cyc();
        b_wr_valid = 0;
        chk("t5_err_gone", b_wr_err, 1'b0);
        chk("t5_idle_write", b_ins[7*DW +: DW], 20'h00777);
        idle(1);

        // clr and beat together in an open burst
        beat(12, DW'($urandom), 1, 0);
        beat(0, DW'($urandom), 0, 0);
        clr = 1; wr_valid = 1; wr_data = 20'hFEDCB;
        #1;
        chk("t6_ready_low", wr_ready, 1'b0);
        cyc();
        chk("t6_no_write", ins[14*DW +: DW], 20'h0);
        chk("t6_busy", busy, 1'b1);
        idle(NA);
        chk("t6_swept", ins, '0);
`ifdef TBL_PACK_VLD_EN
        chk("t6_vld_zero", vld, '0);
`endif

        // Randomised traffic on both instances
        for (int k = 0; k < 400; k++) begin
            clr = ($urandom_range(0, 40) == 0);
            wr_valid = 1'($urandom_range(0, 1));
            wr_idx = 5'($urandom_range(0, 31));
            wr_burst = ($urandom_range(0, 3) == 0);
            wr_last = ($urandom_range(0, 2) == 0);
            wr_data = DW'($urandom);
            b_wr_valid = 1'($urandom_range(0, 1));
            b_wr_idx = 5'($urandom_range(0, 31));
            b_wr_burst = ($urandom_range(0, 3) == 0);
            b_wr_last = ($urandom_range(0, 2) == 0);
            b_wr_data = DW'($urandom);
            cyc();
        end
        idle(NA + 1);

        // Reset in the middle of a burst, then in the middle of a sweep
        beat(4, DW'($urandom), 1, 0);
        beat(0, DW'($urandom), 0, 0);
        wr_valid = 0;
        rst_n = 0;
        #2;
        model_reset();
        reset_checks("rst_burst");
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(1);
        beat(9, 20'h0BEEF, 0, 0);
        clr = 1; wr_valid = 0;
        cyc();
        clr = 0;
        idle(5);
        rst_n = 0;
        #2;
        model_reset();
        reset_checks("rst_sweep");
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
